// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the sequencer state type.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {INIT, RUN, HALTED} seq_state_t;

   function automatic logic is_exc(input logic [2:0] s);
      return (s == SADR) || (s == SINS) || (s == SHLT);
   endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Pure combinational hazard classification from the current stage-register contents.
module pipe_hazard_detect
   import y86_pkg::*;
(
   input  logic [3:0] d_icode_i,
   input  logic [3:0] d_srca_i,
   input  logic [3:0] d_srcb_i,
   input  logic [3:0] e_icode_i,
   input  logic [3:0] e_dstm_i,
   input  logic       e_cnd_i,
   input  logic [3:0] m_icode_i,
   input  logic [2:0] m_stat_i,
   input  logic [2:0] w_stat_i,
   output logic       loaduse_o,
   output logic       retp_o,
   output logic       mispred_o,
   output logic       exc_m_o,
   output logic       exc_w_o
);

   always_comb begin
      loaduse_o = ((e_icode_i == IMRMOVQ) || (e_icode_i == IPOPQ)) && (e_dstm_i != RNONE) &&
                  ((e_dstm_i == d_srca_i) || (e_dstm_i == d_srcb_i));
      retp_o    = (d_icode_i == IRET) || (e_icode_i == IRET) || (m_icode_i == IRET);
      mispred_o = (e_icode_i == IJXX) && !e_cnd_i;
      exc_m_o   = is_exc(m_stat_i);
      exc_w_o   = is_exc(w_stat_i);
   end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline-control sequencer: post-reset flush, hazard stall/bubble muxing, freeze on a
// faulting writeback, and saturating hazard statistics.
module pipe_hazard_sequencer
   import y86_pkg::*;
#(
   parameter int unsigned INIT_CYCLES = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_cnd,
   input  logic [3:0]       M_icode,
   input  logic [2:0]       m_stat,
   input  logic [3:0]       W_icode,
   input  logic [2:0]       W_stat,
   input  logic             cnt_clr,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic             halted,
   output logic [2:0]       final_stat,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mp_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   localparam int unsigned IW = $clog2(INIT_CYCLES + 1);
   localparam logic [IW-1:0] InitLast = IW'(INIT_CYCLES - 1);

   seq_state_t state_q;
   logic [IW-1:0] init_ctr_q;
   logic halted_q;
   logic [2:0] final_stat_q;
   logic loaduse, retp, mispred, exc_m, exc_w;

   pipe_hazard_detect u_detect (
      .d_icode_i (D_icode),
      .d_srca_i  (d_srcA),
      .d_srcb_i  (d_srcB),
      .e_icode_i (E_icode),
      .e_dstm_i  (E_dstM),
      .e_cnd_i   (e_cnd),
      .m_icode_i (M_icode),
      .m_stat_i  (m_stat),
      .w_stat_i  (W_stat),
      .loaduse_o (loaduse),
      .retp_o    (retp),
      .mispred_o (mispred),
      .exc_m_o   (exc_m),
      .exc_w_o   (exc_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= INIT;
         init_ctr_q   <= '0;
         halted_q     <= 1'b0;
         final_stat_q <= SAOK;
      end else begin
         unique case (state_q)
            INIT: begin
               init_ctr_q <= init_ctr_q + 1'b1;
               if (init_ctr_q == InitLast) state_q <= RUN;
            end
            RUN: begin
               if (exc_w) begin
                  state_q      <= HALTED;
                  halted_q     <= 1'b1;
                  final_stat_q <= W_stat;
               end
            end
            HALTED: ;
            default: state_q <= INIT;
         endcase
      end
   end

   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
      unique case (state_q)
         INIT: begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
         end
         RUN: begin
            F_stall  = loaduse | retp;
            D_stall  = loaduse;
            // A load/use stall holds D, so a pending ret must not also bubble it.
            D_bubble = mispred | (retp & ~loaduse);
            E_bubble = mispred | loaduse;
            M_bubble = exc_m | exc_w;
            W_stall  = exc_w;
            set_cc   = (E_icode == IOPQ) & ~exc_m & ~exc_w;
         end
         HALTED: begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
         end
         default: ;
      endcase
   end

   assign halted     = halted_q;
   assign final_stat = final_stat_q;

   // Counter order: cycle, retire, load/use, mispredict, ret.
   logic [CNT_W-1:0] cnt_q [5];
   logic [CNT_W-1:0] cnt_d [5];
   logic [4:0]       cnt_inc;

   always_comb begin
      cnt_inc = {(retp & ~loaduse), mispred, loaduse,
                 ((W_stat == SAOK) && (W_icode != INOP)), 1'b1};
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr) begin
            cnt_d[i] = '0;
         end else if ((state_q == RUN) && cnt_inc[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign cyc_cnt    = cnt_q[0];
   assign retire_cnt = cnt_q[1];
   assign lu_cnt     = cnt_q[2];
   assign mp_cnt     = cnt_q[3];
   assign ret_cnt    = cnt_q[4];

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench: each stimulus cycle queues its expected controls; a negedge monitor checks.
module tb_pipe_hazard_sequencer;
   import y86_pkg::*;

   localparam int unsigned CW = 4;

   // Control vector order: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
   localparam logic [6:0] C_INIT = 7'b1011100;
   localparam logic [6:0] C_HALT = 7'b1101110;
   localparam logic [6:0] C_NONE = 7'b0000000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
   logic e_cnd, cnt_clr;
   logic [2:0] m_stat, W_stat;
   logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
   logic [2:0] final_stat;
   logic [CW-1:0] cyc_cnt, retire_cnt, lu_cnt, mp_cnt, ret_cnt;

   pipe_hazard_sequencer #(.INIT_CYCLES(4), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .D_icode    (D_icode),
      .d_srcA     (d_srcA),
      .d_srcB     (d_srcB),
      .E_icode    (E_icode),
      .E_dstM     (E_dstM),
      .e_cnd      (e_cnd),
      .M_icode    (M_icode),
      .m_stat     (m_stat),
      .W_icode    (W_icode),
      .W_stat     (W_stat),
      .cnt_clr    (cnt_clr),
      .F_stall    (F_stall),
      .D_stall    (D_stall),
      .D_bubble   (D_bubble),
      .E_bubble   (E_bubble),
      .M_bubble   (M_bubble),
      .W_stall    (W_stall),
      .set_cc     (set_cc),
      .halted     (halted),
      .final_stat (final_stat),
      .cyc_cnt    (cyc_cnt),
      .retire_cnt (retire_cnt),
      .lu_cnt     (lu_cnt),
      .mp_cnt     (mp_cnt),
      .ret_cnt    (ret_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [6:0]    ctrl;
      logic          halted;
      logic [2:0]    fstat;
      logic          chk_cnt;
      logic [CW-1:0] cyc, rt, lu, mp, ret;
   } exp_t;

   exp_t sb[$];
   int n_tests = 0;
   int n_fail = 0;

   task automatic idle();
      D_icode = INOP; E_icode = INOP; M_icode = INOP; W_icode = INOP;
      d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE; e_cnd = 1'b0;
      m_stat = SAOK; W_stat = SAOK; cnt_clr = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic expect_ctl(input string name, input logic [6:0] ctrl, input logic h,
                             input logic [2:0] fs);
      exp_t e;
      e.name = name; e.ctrl = ctrl; e.halted = h; e.fstat = fs; e.chk_cnt = 1'b0;
      e.cyc = '0; e.rt = '0; e.lu = '0; e.mp = '0; e.ret = '0;
      sb.push_back(e);
   endtask

   task automatic expect_all(input string name, input logic [6:0] ctrl, input logic h,
                             input logic [2:0] fs, input int cyc, input int rt, input int lu,
                             input int mp, input int ret);
      exp_t e;
      e.name = name; e.ctrl = ctrl; e.halted = h; e.fstat = fs; e.chk_cnt = 1'b1;
      e.cyc = CW'(cyc); e.rt = CW'(rt); e.lu = CW'(lu); e.mp = CW'(mp); e.ret = CW'(ret);
      sb.push_back(e);
   endtask

   // Monitor: every queued expectation is checked against the DUT mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [6:0] act;
         e = sb.pop_front();
         act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
         n_tests++;
         if (act !== e.ctrl) begin
            n_fail++;
            $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
         end
         n_tests++;
         if (halted !== e.halted || final_stat !== e.fstat) begin
            n_fail++;
            $display("FAIL %s status: got halted=%b stat=%0d expected halted=%b stat=%0d",
                     e.name, halted, final_stat, e.halted, e.fstat);
         end
         if (e.chk_cnt) begin
            n_tests++;
            if ({cyc_cnt, retire_cnt, lu_cnt, mp_cnt, ret_cnt} !==
                {e.cyc, e.rt, e.lu, e.mp, e.ret}) begin
               n_fail++;
               $display("FAIL %s counters: got cyc=%0d rt=%0d lu=%0d mp=%0d ret=%0d expected cyc=%0d rt=%0d lu=%0d mp=%0d ret=%0d",
                        e.name, cyc_cnt, retire_cnt, lu_cnt, mp_cnt, ret_cnt,
                        e.cyc, e.rt, e.lu, e.mp, e.ret);
            end
         end
      end
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);

      // Release reset: four flush cycles, then RUN with cyc_cnt from zero.
      next_cycle(); rst_n = 1'b1;
      expect_all("init0", C_INIT, 1'b0, SAOK, 0, 0, 0, 0, 0);
      next_cycle(); expect_ctl("init1", C_INIT, 1'b0, SAOK);
      next_cycle(); expect_ctl("init2", C_INIT, 1'b0, SAOK);
      next_cycle(); expect_all("init3", C_INIT, 1'b0, SAOK, 0, 0, 0, 0, 0);
      next_cycle(); expect_all("run0", C_NONE, 1'b0, SAOK, 0, 0, 0, 0, 0);
      next_cycle(); expect_all("run1", C_NONE, 1'b0, SAOK, 1, 0, 0, 0, 0);

      next_cycle(); E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcB = 4'd3;
      expect_all("loaduse", 7'b1101000, 1'b0, SAOK, 2, 0, 0, 0, 0);
      next_cycle(); E_icode = IMRMOVQ; E_dstM = RNONE; d_srcA = RNONE; d_srcB = 4'd3;
      expect_all("lu_rnone", C_NONE, 1'b0, SAOK, 3, 0, 1, 0, 0);

      next_cycle(); D_icode = IRET;
      expect_all("ret_d", 7'b1010000, 1'b0, SAOK, 4, 0, 1, 0, 0);
      next_cycle(); E_icode = IRET;
      expect_ctl("ret_e", 7'b1010000, 1'b0, SAOK);
      next_cycle(); M_icode = IRET;
      expect_ctl("ret_m", 7'b1010000, 1'b0, SAOK);
      next_cycle(); D_icode = IRET; E_icode = IJXX; e_cnd = 1'b0;
      expect_all("ret_mispred", 7'b1011000, 1'b0, SAOK, 7, 0, 1, 0, 3);
      next_cycle(); M_icode = IRET; E_icode = IPOPQ; E_dstM = 4'd4; d_srcA = 4'd4;
      expect_all("ret_loaduse", 7'b1101000, 1'b0, SAOK, 8, 0, 1, 1, 4);
      next_cycle(); W_icode = IOPQ;
      expect_all("retire", C_NONE, 1'b0, SAOK, 9, 0, 2, 1, 4);
      next_cycle(); E_icode = IJXX; e_cnd = 1'b1;
      expect_all("jxx_taken", C_NONE, 1'b0, SAOK, 10, 1, 2, 1, 4);

      next_cycle(); E_icode = IOPQ;
      expect_ctl("setcc", 7'b0000001, 1'b0, SAOK);
      next_cycle(); E_icode = IOPQ; m_stat = SADR;
      expect_all("setcc_mexc", 7'b0000100, 1'b0, SAOK, 12, 1, 2, 1, 4);
      next_cycle(); W_icode = IMRMOVQ; W_stat = SADR;
      expect_all("w_exc", 7'b0000110, 1'b0, SAOK, 13, 1, 2, 1, 4);
      next_cycle();
      expect_all("halted_adr", C_HALT, 1'b1, SADR, 14, 1, 2, 1, 4);
      next_cycle(); E_icode = IMRMOVQ; E_dstM = 4'd2; d_srcA = 4'd2; W_icode = IOPQ;
      expect_all("halted_frozen", C_HALT, 1'b1, SADR, 14, 1, 2, 1, 4);

      // Asynchronous reset while HALTED, then the SHLT path.
      next_cycle(); rst_n = 1'b0;
      expect_all("async_rst_a", C_INIT, 1'b0, SAOK, 0, 0, 0, 0, 0);
      next_cycle(); rst_n = 1'b1; expect_ctl("reinit0", C_INIT, 1'b0, SAOK);
      repeat (3) begin
         next_cycle(); expect_ctl("reinit", C_INIT, 1'b0, SAOK);
      end
      next_cycle(); expect_all("rerun0", C_NONE, 1'b0, SAOK, 0, 0, 0, 0, 0);
      next_cycle(); W_icode = IHALT; W_stat = SHLT;
      expect_ctl("w_hlt", 7'b0000110, 1'b0, SAOK);
      next_cycle();
      expect_all("halted_hlt", C_HALT, 1'b1, SHLT, 2, 0, 0, 0, 0);
      next_cycle(); rst_n = 1'b0;
      expect_all("async_rst_b", C_INIT, 1'b0, SAOK, 0, 0, 0, 0, 0);

      // Saturation: 19 retiring RUN cycles must stop at 15, not wrap.
      next_cycle(); rst_n = 1'b1; expect_ctl("sat_init", C_INIT, 1'b0, SAOK);
      repeat (3) begin
         next_cycle(); expect_ctl("sat_init", C_INIT, 1'b0, SAOK);
      end
      repeat (19) begin
         next_cycle(); W_icode = IOPQ; expect_ctl("sat_run", C_NONE, 1'b0, SAOK);
      end
      next_cycle(); W_icode = IOPQ;
      expect_all("sat_hold", C_NONE, 1'b0, SAOK, 15, 15, 0, 0, 0);
      next_cycle(); W_icode = IOPQ; cnt_clr = 1'b1;
      expect_all("clr_pre", C_NONE, 1'b0, SAOK, 15, 15, 0, 0, 0);
      next_cycle(); W_icode = IOPQ;
      expect_all("clr_post", C_NONE, 1'b0, SAOK, 0, 0, 0, 0, 0);
      next_cycle();
      expect_all("after_clr", C_NONE, 1'b0, SAOK, 1, 1, 0, 0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no completion expected finish before 20000");
      $fatal(1, "timeout");
   end

endmodule
